// File: rtl/booth_mul_seq_if.sv
// Handshake and operand/result bundle for booth_mul_seq.
//   master : drives start and operands, observes busy/done/hi/lo
//   slave  : the multiplier itself
interface booth_mul_seq_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] multiplicand;
   logic [WIDTH-1:0] multiplier;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, multiplicand, multiplier,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, multiplicand, multiplier,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth signed multiplier, one Booth step per clock.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of booth_mul_seq_if
//             start/multiplicand/multiplier in; busy/done/hi/lo out.
// A request is accepted only in IDLE; done pulses one cycle after WIDTH
// steps and hi/lo hold the signed 2*WIDTH-bit product until the next one.
module booth_mul_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic                 clock,
   input  logic                 reset_n,
   booth_mul_seq_if.slave       bus
);

   localparam int unsigned AW = WIDTH + 1;
   localparam int unsigned CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] m_q,     m_d;
   logic [AW-1:0]    a_q,     a_d;
   logic [WIDTH-1:0] q_q,     q_d;
   logic             qm1_q,   qm1_d;
   logic [CW-1:0]    cnt_q,   cnt_d;
   logic             busy_q,  busy_d;
   logic             done_q,  done_d;
   logic [WIDTH-1:0] hi_q,    hi_d;
   logic [WIDTH-1:0] lo_q,    lo_d;

   logic [AW-1:0]    m_sext;
   logic [AW-1:0]    a_sum;

   // Booth add/subtract on the sign-extended multiplicand; AW bits keep
   // the most negative multiplicand from overflowing.
   always_comb begin
      m_sext = {m_q[WIDTH-1], m_q};
      unique case ({q_q[0], qm1_q})
         2'b01:   a_sum = a_q + m_sext;
         2'b10:   a_sum = a_q - m_sext;
         default: a_sum = a_q;
      endcase
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      a_d     = a_q;
      q_d     = q_q;
      qm1_d   = qm1_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;

      unique case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (bus.start) begin
               m_d     = bus.multiplicand;
               q_d     = bus.multiplier;
               a_d     = '0;
               qm1_d   = 1'b0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            // Arithmetic right shift of {A,Q,q_m1} after the add step.
            a_d   = {a_sum[AW-1], a_sum[AW-1:1]};
            q_d   = {a_sum[0], q_q[WIDTH-1:1]};
            qm1_d = q_q[0];
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               hi_d    = a_sum[WIDTH:1];
               lo_d    = {a_sum[0], q_q[WIDTH-1:1]};
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = DONE;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         m_q     <= '0;
         a_q     <= '0;
         q_q     <= '0;
         qm1_q   <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         a_q     <= a_d;
         q_q     <= q_d;
         qm1_q   <= qm1_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule
